// File: rtl/oric_ram_arbiter.sv
// Oric 48K main RAM arbiter: video > cpu > downloader, with starvation relief for the downloader.
// Optional build macro ARB_ROM_PROTECT_EN blocks CPU writes to 0xC000-0xFFFF.
module oric_ram_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk_sys,
  input  logic          RESET,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_ack,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic          cpu_ack,
  input  logic          dl_req,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_din,
  output logic          dl_ack,
  output logic [DW-1:0] rdata,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, CYCLE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {WIN_VID, WIN_CPU, WIN_DL} win_t;

  state_t     state;
  win_t       win;
  logic [3:0] starve;

  logic dl_force;
  logic grant_cpu;
  logic grant_dl;
  logic cpu_wr;

  always_comb begin
    dl_force  = dl_req && (starve == STARVE_LIM);
    grant_dl  = !vid_req && dl_req && (dl_force || !cpu_req);
    grant_cpu = !vid_req && cpu_req && !dl_force;
`ifdef ARB_ROM_PROTECT_EN
    // ROM shadow: the access still runs and acks, only the strobe is dropped
    cpu_wr    = cpu_we && (cpu_addr[AW-1:AW-2] != 2'b11);
`else
    cpu_wr    = cpu_we;
`endif
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state    <= IDLE;
      win      <= WIN_VID;
      starve   <= '0;
      ram_ce   <= 1'b0;
      ram_we   <= 1'b0;
      ram_addr <= '0;
      ram_din  <= '0;
      rdata    <= '0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      dl_ack   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dl_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (!dl_req || grant_dl)
            starve <= '0;
          else if (grant_cpu && (starve != STARVE_LIM))
            starve <= starve + 4'd1;

          if (vid_req) begin
            win      <= WIN_VID;
            ram_addr <= vid_addr;
            ram_we   <= 1'b0;
          end else if (grant_cpu) begin
            win      <= WIN_CPU;
            ram_addr <= cpu_addr;
            ram_din  <= cpu_din;
            ram_we   <= cpu_wr;
          end else if (grant_dl) begin
            win      <= WIN_DL;
            ram_addr <= dl_addr;
            ram_din  <= dl_din;
            ram_we   <= 1'b1;
          end

          if (vid_req || cpu_req || dl_req) begin
            state  <= CYCLE;
            ram_ce <= 1'b1;
            busy   <= 1'b1;
          end
        end
        CYCLE: begin
          ram_ce <= 1'b0;
          ram_we <= 1'b0;
          state  <= WAIT;
        end
        WAIT: begin
          rdata <= ram_dout;
          state <= DONE;
          case (win)
            WIN_VID: vid_ack <= 1'b1;
            WIN_CPU: cpu_ack <= 1'b1;
            WIN_DL:  dl_ack  <= 1'b1;
            default: ;
          endcase
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/oric_ram_arbiter.md
Name: oric_ram_arbiter

Overview:
- Single-port arbiter/sequencer for the Oric 48K main RAM, clocked on the system clock.
- Shares one synchronous RAM port between three requesters: ULA video fetch, 6502 CPU, and the SD/OSD downloader (ioctl ROM/tape image injection).
- Sequences each access as a fixed 4-cycle transaction with a req/ack handshake.
- Sits between oricatmos core logic and the RAM macro.

Parameters:
- AW, 16, address width (64 KB space)
- DW, 8, data width
- STARVE_MAX, 4, CPU grants in a row, while dl_req is pending, before the downloader is forced ahead of the CPU (range 1..15)

Ports:
- clk_sys  in  1  system clock (24 MHz)
- RESET  in  1  synchronous, active-high reset
- vid_req  in  1  video read request
- vid_addr  in  AW  video address
- vid_ack  out  1  one-cycle pulse; rdata valid
- cpu_req  in  1  CPU request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_ack  out  1  one-cycle pulse; rdata valid on reads
- dl_req  in  1  downloader write request (write-only)
- dl_addr  in  AW  downloader address
- dl_din  in  DW  downloader write data
- dl_ack  out  1  one-cycle pulse
- rdata  out  DW  read data; shared by all requesters
- ram_ce  out  1  RAM cycle enable
- ram_we  out  1  RAM write enable
- ram_addr  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid the cycle after the ce cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- All outputs are registered.
- Reset values: state = IDLE; ram_ce, ram_we, all acks and busy = 0; ram_addr, ram_din and rdata = 0; starve counter = 0.
- FSM: IDLE -> CYCLE -> WAIT -> DONE -> IDLE. No other transitions, except that RESET returns to IDLE from any state.
- IDLE, with any req high: latch the winner, its address, data and we. Next cycle (CYCLE) drives ram_ce = 1, ram_we, ram_addr, ram_din.
- CYCLE: ram_ce = 1 for exactly this one cycle. ram_we = 1 only for write grants.
- WAIT: ram_ce = 0, ram_we = 0. rdata <= ram_dout.
- DONE: the winner's ack = 1 for exactly one cycle. rdata holds the read value from DONE until the next WAIT. On writes rdata is don't-care but is still updated.
- Latency: req sampled at T0, RAM cycle at T1, ack at T3, next arbitration at T4. Peak throughput is 1 access per 4 clocks.
- Requester contract:
  - req, addr, din and we stay stable from assertion until ack.
  - req drops in the cycle after ack.
  - A req still high at T4 is treated as a new request.
- Priority, evaluated in IDLE only:
  - video > cpu > dl,
  - except when the starve counter == STARVE_MAX and dl_req = 1: then dl > cpu.
  - Video is never preempted.
- Starve counter:
  - increments (saturating at STARVE_MAX) on each CPU grant while dl_req = 1;
  - clears on a dl grant, or in any IDLE cycle with dl_req = 0;
  - video grants leave it unchanged.
- A request arriving mid-transaction waits; it is not lost.
- Requests arriving simultaneously resolve in one IDLE cycle by the priority above.
- Reset mid-operation:
  - no ack is issued; state goes to IDLE on the next edge;
  - ram_ce and ram_we are 0 from the cycle after reset;
  - a write already in CYCLE at the reset edge counts as performed, and is otherwise aborted.
- Addresses pass through unmodified; no wrap logic is needed (full AW decode).

Optional Feature:
- Macro: ARB_ROM_PROTECT_EN.
- Defined: a CPU write with cpu_addr[15:14] == 2'b11 (0xC000-0xFFFF, ROM shadow) still runs the full 4-cycle sequence and still acks, but ram_we stays 0 in CYCLE, so memory is unchanged. Downloader writes to that region are always allowed.
- Undefined: no address filtering; all writes reach RAM.

Test Plan:
- CPU write then read: write 0x5A to 0x0400 with cpu_we = 1, then read 0x0400 -> ram_ce/ram_we pulse at T1 of the write; the read acks at T3 with rdata = 0x5A; each access takes 4 clocks.
- Collision: vid_req (0xBB80) and cpu_req (0x0500) raised in the same cycle -> vid_ack first at T3; cpu_ack at T7; each ack is exactly one cycle wide.
- Starvation: cpu_req held back-to-back and dl_req held with dl_addr 0x1000, dl_din 0x33, STARVE_MAX = 4 -> 4 CPU grants, then a dl grant with a ram_we pulse at 0x1000/0x33, then the counter is 0 and the CPU resumes.
- Reset mid-read: RESET asserted while in WAIT -> no ack is issued; busy = 0 and ram_ce = 0 the next cycle; a pending cpu_req is re-arbitrated after reset release.
- ROM protect (macro defined): CPU writes 0xFF to 0xC010 -> cpu_ack at T3, ram_we stays 0 throughout; a dl write to 0xC010 does assert ram_we. With the macro undefined, the same CPU write asserts ram_we.
- Idle: no req for 100 cycles -> busy, ram_ce, ram_we and all acks stay 0, and rdata is unchanged.
